// File: rtl/usb_tx_encoder.sv
// Full-speed USB bit-level transmitter: byte stream in, SYNC + bit-stuffed NRZI + EOP out on D+/D-.
// The line idles at J; one byte of buffering decouples the packet layer from the bit clock.
module usb_tx_encoder #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_underrun
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } state_e;

  localparam logic [7:0] LAST_CNT  = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [2:0] MAX_ONES  = 3'd6;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       last_seen_q, last_seen_d;
  logic [2:0] ones_q, ones_d;
  logic       line_j_q, line_j_d;
  logic       se0_q, se0_d;
  logic       underrun_q, underrun_d;

  logic       ready_int;
  logic       xfer;
  logic       wrap;
  logic       send_bit;
  logic       cur_bit;
  logic [7:0] byte_src;

  assign wrap = (cnt_q == LAST_CNT);

  always_comb begin
    unique case (state_q)
      ST_IDLE:          ready_int = 1'b1;
      ST_SYNC, ST_DATA: ready_int = ~hold_full_q & ~last_seen_q;
      default:          ready_int = 1'b0;
    endcase
  end

  // Gated by rst so the handshake stays closed for the whole reset window.
  assign tx_ready = ~rst & ready_int;
  assign xfer     = tx_valid & tx_ready;

  // NOTE: every variable gets its default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = wrap ? 8'd0 : cnt_q + 8'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_seen_d = last_seen_q;
    ones_d      = ones_q;
    line_j_d    = line_j_q;
    se0_d       = se0_q;
    underrun_d  = 1'b0;
    send_bit    = 1'b0;
    cur_bit     = 1'b0;
    byte_src    = hold_full_q ? hold_q : tx_data;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d    = 8'd0;
        line_j_d = 1'b1;
        se0_d    = 1'b0;
        if (xfer) begin
          hold_d      = tx_data;
          hold_full_d = 1'b1;
          last_seen_d = tx_last;
          shift_d     = SYNC_BYTE[7:1];
          bit_idx_d   = 3'd0;
          ones_d      = 3'd0;
          line_j_d    = 1'b0;
          state_d     = ST_SYNC;
        end
      end

      ST_SYNC, ST_DATA: begin
        if (xfer) begin
          hold_d      = tx_data;
          hold_full_d = 1'b1;
          last_seen_d = tx_last;
        end
        if (wrap) begin
          if (ones_q == MAX_ONES) begin
            // Stuffed zero: the shift register and bit index hold still.
            line_j_d = ~line_j_q;
            ones_d   = 3'd0;
          end else if (bit_idx_q != 3'd7) begin
            send_bit  = 1'b1;
            cur_bit   = shift_q[0];
            shift_d   = {1'b0, shift_q[6:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end else if (hold_full_q || xfer) begin
            // A byte arriving on the boundary cycle is taken straight into the shifter.
            send_bit    = 1'b1;
            cur_bit     = byte_src[0];
            shift_d     = byte_src[7:1];
            bit_idx_d   = 3'd0;
            hold_full_d = 1'b0;
            state_d     = ST_DATA;
          end else begin
            underrun_d = ~last_seen_q;
            se0_d      = 1'b1;
            bit_idx_d  = 3'd0;
            state_d    = ST_EOP_SE0;
          end
        end
      end

      ST_EOP_SE0: begin
        if (wrap) begin
          if (bit_idx_q == 3'd0) begin
            bit_idx_d = 3'd1;
          end else begin
            se0_d    = 1'b0;
            line_j_d = 1'b1;
            state_d  = ST_EOP_J;
          end
        end
      end

      ST_EOP_J: begin
        if (wrap) begin
          state_d     = ST_IDLE;
          last_seen_d = 1'b0;
          hold_full_d = 1'b0;
          ones_d      = 3'd0;
          bit_idx_d   = 3'd0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // NRZI: a 0 toggles the line, a 1 holds it; ones run resets on any 0.
    if (send_bit) begin
      line_j_d = cur_bit ? line_j_q : ~line_j_q;
      ones_d   = cur_bit ? ones_q + 3'd1 : 3'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 7'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      last_seen_q <= 1'b0;
      ones_q      <= 3'd0;
      line_j_q    <= 1'b1;
      se0_q       <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_seen_q <= last_seen_d;
      ones_q      <= ones_d;
      line_j_q    <= line_j_d;
      se0_q       <= se0_d;
      underrun_q  <= underrun_d;
    end
  end

  assign d_plus      = ~se0_q & line_j_q;
  assign d_minus     = ~se0_q & ~line_j_q;
  assign tx_busy     = (state_q != ST_IDLE);
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: line symbols per bit period, busy length,
// handshake and underrun timing against hand-derived sequences.
module tb_usb_tx_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       d_plus;
  logic       d_minus;
  logic       tx_busy;
  logic       tx_underrun;

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned sym [0:511];
  byte unsigned pkt [0:3];

  usb_tx_encoder #(.CLKS_PER_BIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .d_plus     (d_plus),
    .d_minus    (d_minus),
    .tx_busy    (tx_busy),
    .tx_underrun(tx_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic byte unsigned line_sym();
    case ({d_plus, d_minus})
      2'b10:   return "J";
      2'b01:   return "K";
      2'b00:   return "0";
      default: return "X";
    endcase
  endfunction

  // Offers pkt[0..n-1] with tx_valid held high, records one line symbol per busy cycle
  // (cycle 0 = first cycle after the first accept) and checks the whole packet.
  task automatic run_packet(input string name, input int n, input bit final_last,
                            input string exp, input int exp_ready, input int exp_und_at,
                            input int exp_acc2);
    int idx = 0;
    int ncap = 0;
    int und_cnt = 0;
    int und_at = -1;
    int ready_cnt = 0;
    int acc2 = -1;
    bit xfer_prev;
    bit started = 1'b0;
    bit done = 1'b0;

    @(negedge clk);
    tx_data   = pkt[0];
    tx_valid  = 1'b1;
    tx_last   = (n == 1) && final_last;
    xfer_prev = tx_ready;
    for (int t = 0; t < 600 && !done; t++) begin
      @(negedge clk);
      if (xfer_prev) begin
        idx++;
        if (idx == 1) started = 1'b1;
        else if (idx == 2) acc2 = ncap - 1;
        if (idx < n) begin
          tx_data = pkt[idx];
          tx_last = (idx == n - 1) && final_last;
        end else begin
          tx_valid = 1'b0;
          tx_last  = 1'b0;
        end
      end
      if (started) begin
        if (!tx_busy) begin
          done = 1'b1;
        end else begin
          sym[ncap] = line_sym();
          if (tx_underrun) begin
            und_cnt++;
            if (und_at < 0) und_at = ncap;
          end
          if (tx_ready) ready_cnt++;
          ncap++;
        end
      end
      xfer_prev = tx_valid && tx_ready;
    end

    check({name, " finished in time"}, int'(done), 1);
    check({name, " busy cycles"}, ncap, exp.len() * 8);
    for (int k = 0; k < exp.len(); k++) begin
      check($sformatf("%s bit%0d start", name, k), int'(sym[k * 8]), int'(exp[k]));
      check($sformatf("%s bit%0d end", name, k), int'(sym[k * 8 + 7]), int'(exp[k]));
    end
    check({name, " ready cycles"}, ready_cnt, exp_ready);
    check({name, " underrun pulses"}, und_cnt, (exp_und_at < 0) ? 0 : 1);
    check({name, " underrun cycle"}, und_at, exp_und_at);
    check({name, " second accept cycle"}, acc2, exp_acc2);
    check({name, " idle line"}, int'(line_sym()), int'("J"));
    check({name, " idle ready"}, int'(tx_ready), 1);
  endtask

  initial begin
    string sync_s;
    int se0_seen;
    int busy_seen;

    sync_s = "KJKJKJKK";

    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    tx_last  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("reset%0d d_plus", i), int'(d_plus), 1);
      check($sformatf("reset%0d d_minus", i), int'(d_minus), 0);
      check($sformatf("reset%0d busy", i), int'(tx_busy), 0);
      check($sformatf("reset%0d ready", i), int'(tx_ready), 0);
      check($sformatf("reset%0d underrun", i), int'(tx_underrun), 0);
    end
    rst      = 1'b0;
    tx_valid = 1'b0;
    #1;
    check("ready after reset", int'(tx_ready), 1);

    pkt[0] = 8'h00;
    run_packet("byte00", 1, 1'b1, {sync_s, "JKJKJKJK", "00J"}, 0, -1, -1);

    pkt[0] = 8'hFF;
    run_packet("byteFF", 1, 1'b1, {sync_s, "KKKKKJJJJ", "00J"}, 0, -1, -1);

    pkt[0] = 8'hA5;
    pkt[1] = 8'h3C;
    run_packet("a5_3c", 2, 1'b1, {sync_s, "KJJKJJKK", "JKKKKKJK", "00J"}, 1, -1, 64);

    pkt[0] = 8'h12;
    run_packet("underrun", 1, 1'b0, {sync_s, "JJKJJKJK", "00J"}, 64, 128, -1);

    // Reset during data bit 3 of a single-byte packet.
    @(negedge clk);
    tx_data  = 8'h00;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    check("midrst started", int'(tx_busy), 1);
    repeat (90) @(negedge clk);
    check("midrst in data", int'(tx_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst d_plus", int'(d_plus), 1);
    check("midrst d_minus", int'(d_minus), 0);
    check("midrst busy", int'(tx_busy), 0);
    rst = 1'b0;
    se0_seen  = 0;
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (!d_plus && !d_minus) se0_seen++;
      if (tx_busy) busy_seen++;
    end
    check("midrst no eop", se0_seen, 0);
    check("midrst stays idle", busy_seen, 0);
    check("midrst ready", int'(tx_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
